gpio_change_tracer: RTL

- Synthesizable successor to the bench-side LED change printer; lives inside SOC next to the LED/BUTTONS logic.
- Watches a WIDTH-bit input bus, synchronises it and timestamps every value change.
- Queues each change as a {value, timestamp} record in a FIFO that the CPU or a debug UART drains through a valid/ready port.
- Adds sample prescaling, overflow detection and an optional debounce.

---
 rtl/gpio_change_tracer_if.sv | 12 +
 rtl/gpio_change_tracer.sv | 101 ++++++++++
 2 files changed

// File: rtl/gpio_change_tracer_if.sv
// gpio_change_tracer_if: valid/ready read port carrying {value, timestamp} records
interface gpio_change_tracer_if #(
  parameter int WIDTH    = 5,
  parameter int TS_WIDTH = 16
);
  logic                rd_valid;
  logic                rd_ready;
  logic [WIDTH-1:0]    rd_data;
  logic [TS_WIDTH-1:0] rd_time;
  modport master (output rd_valid, rd_data, rd_time, input rd_ready);
  modport slave  (input rd_valid, rd_data, rd_time, output rd_ready);
endinterface

// File: rtl/gpio_change_tracer.sv
// gpio_change_tracer: timestamps input bus changes into a FWFT FIFO (optional debounce via TRACER_DEBOUNCE_EN)
module gpio_change_tracer #(
  parameter int WIDTH          = 5,
  parameter int DEPTH          = 16,
  parameter int TS_WIDTH       = 16,
  parameter int SAMPLE_DIV     = 1,
  parameter int DEBOUNCE_TICKS = 4
) (
  input  logic                    CLK,
  input  logic                    RESET,
  input  logic [WIDTH-1:0]        sample_in,
  input  logic                    enable,
  input  logic                    clear,
  gpio_change_tracer_if.master    rd,
  output logic [$clog2(DEPTH):0]  count,
  output logic                    overflow
);
  localparam int AW = $clog2(DEPTH);
  localparam int PW = SAMPLE_DIV > 1 ? $clog2(SAMPLE_DIV) : 1;
  logic [WIDTH-1:0]          sync1_q, sync2_q, prev_q, prev_d;
  logic [PW-1:0]             pre_q, pre_d;
  logic [TS_WIDTH-1:0]       ts_q, ts_d;
  logic [AW-1:0]             wp_q, wp_d, rp_q, rp_d;
  logic [AW:0]               cnt_q, cnt_d;
  logic                      ovf_q, ovf_d;
  logic [WIDTH+TS_WIDTH-1:0] mem_q [DEPTH];
  logic                      tick, accept, push, pop, wr, valid;

  assign tick = pre_q == PW'(SAMPLE_DIV - 1);

`ifdef TRACER_DEBOUNCE_EN
  localparam int CW = $clog2(DEBOUNCE_TICKS + 1);
  logic [WIDTH-1:0] cand_q;
  logic [CW-1:0]    db_q;
  logic             same;
  assign same   = sync2_q == cand_q;
  assign accept = tick && sync2_q != prev_q && same && db_q == CW'(DEBOUNCE_TICKS);
  // Count consecutive ticks a new value has held; any other value restarts the run
  always_ff @(posedge CLK or negedge RESET)
    if (!RESET) begin
      cand_q <= '0;
      db_q   <= '0;
    end else if (tick) begin
      cand_q <= sync2_q;
      db_q   <= (sync2_q == prev_q || accept) ? '0 : !same ? CW'(1) : db_q + CW'(1);
    end
`else
  logic unused_db;
  assign unused_db = DEBOUNCE_TICKS != 0;
  assign accept    = tick && sync2_q != prev_q;
`endif

  assign valid = cnt_q != '0;
  assign push  = accept && enable && !clear;
  assign pop   = valid && rd.rd_ready && !clear;
  assign wr    = push && (cnt_q != (AW+1)'(DEPTH) || pop);

  // Next state: clear flushes queue/time but keeps change history; a push into a full queue without a pop is dropped
  always_comb begin
    pre_d  = (clear || tick) ? '0 : pre_q + PW'(1);
    ts_d   = clear ? '0 : ts_q + TS_WIDTH'(tick);
    prev_d = accept ? sync2_q : prev_q;
    cnt_d  = clear ? '0 : cnt_q + (AW+1)'(wr) - (AW+1)'(pop);
    ovf_d  = !clear && (ovf_q || (push && !wr));
    wp_d   = clear ? '0 : wp_q + AW'(wr);
    rp_d   = clear ? '0 : rp_q + AW'(pop);
  end

  // Synchroniser runs every clock; the rest advances from the next-state logic
  always_ff @(posedge CLK or negedge RESET)
    if (!RESET) begin
      sync1_q <= '0;
      sync2_q <= '0;
      prev_q  <= '0;
      pre_q   <= '0;
      ts_q    <= '0;
      wp_q    <= '0;
      rp_q    <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      sync1_q <= sample_in;
      sync2_q <= sync1_q;
      prev_q  <= prev_d;
      pre_q   <= pre_d;
      ts_q    <= ts_d;
      wp_q    <= wp_d;
      rp_q    <= rp_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
    end

  // Record storage needs no reset: reads are masked while the queue is empty
  always_ff @(posedge CLK)
    if (wr) mem_q[wp_q] <= {sync2_q, ts_q};

  assign rd.rd_valid              = valid;
  assign {rd.rd_data, rd.rd_time} = valid ? mem_q[rp_q] : '0;
  assign count                    = cnt_q;
  assign overflow                 = ovf_q;
endmodule
